caminho_de_dados: RTL and testbench

//  Datapath paired with the A/B/C control FSM: consumes EnA/EnB/EnC, Sel_in, Sel_R, Op, Op_Reg, fim
//  and executes the two instructions a+b+b-c (instrucao=0) and (a+b+c)/2 (instrucao=1).

---
 rtl/caminho_de_dados.sv | 125 ++++++++++++
 tb/tb_caminho_de_dados.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/caminho_de_dados.sv
// rtl/caminho_de_dados.sv - datapath for the A/B/C control FSM (a+b+b-c and (a+b+c)/2)
//
// Purpose:
//   Operand registers A, B, C fed from the external bus or the ULA result.
//   A combinational ULA (X is always A; Y is B or C).
//   Result register D, which can hold, load C, shift right by one or clear.
//   A sticky carry/borrow flag, and a one-cycle "pronto" strobe that trails fim.
//
// Ports:
//   clk     in  1   clock, rising edge
//   rst     in  1   asynchronous reset, active low
//   dados   in  N   external operand bus
//   EnA     in  1   load enable for A
//   EnB     in  1   load enable for B
//   EnC     in  1   load enable for C
//   Sel_in  in  1   register source: 0 = dados, 1 = ULA result
//   Sel_R   in  1   ULA Y operand: 0 = B, 1 = C
//   Op      in  2   ULA op: 00 X, 01 X+Y, 10 X-Y, 11 X&Y
//   Op_Reg  in  2   D op: 00 hold, 01 load C, 10 shift right 1, 11 clear
//   fim     in  1   end of instruction from control
//   saida   out N   contents of D
//   carry   out 1   sticky carry / borrow
//   pronto  out 1   result-valid strobe
module caminho_de_dados #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] dados,
  input  logic         EnA,
  input  logic         EnB,
  input  logic         EnC,
  input  logic         Sel_in,
  input  logic         Sel_R,
  input  logic [1:0]   Op,
  input  logic [1:0]   Op_Reg,
  input  logic         fim,
  output logic [N-1:0] saida,
  output logic         carry,
  output logic         pronto
);

  logic [N-1:0] reg_a;
  logic [N-1:0] reg_b;
  logic [N-1:0] reg_c;
  logic [N-1:0] reg_d;

  logic [N-1:0] ula_y;
  logic [N:0]   ula_sum;
  logic [N-1:0] ula_res;
  logic         ula_cout;
  logic [N-1:0] din;

  assign ula_y   = Sel_R ? reg_c : reg_b;
  assign ula_sum = {1'b0, reg_a} + {1'b0, ula_y};

  always_comb begin
    ula_res  = '0;
    ula_cout = 1'b0;
    case (Op)
      2'b00: ula_res = reg_a;
      2'b01: begin
        ula_res  = ula_sum[N-1:0];
        ula_cout = ula_sum[N];
      end
      2'b10: begin
        ula_res  = reg_a - ula_y;
        ula_cout = (reg_a < ula_y);
      end
      default: ula_res = reg_a & ula_y;
    endcase
  end

  assign din = Sel_in ? ula_res : dados;

  // All enabled registers load the same din, computed from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_a <= '0;
      reg_b <= '0;
      reg_c <= '0;
    end else begin
      if (EnA) reg_a <= din;
      if (EnB) reg_b <= din;
      if (EnC) reg_c <= din;
    end
  end

  // The shift drops any overflow: the carry flag is the only record of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_d <= '0;
    end else begin
      case (Op_Reg)
        2'b01:   reg_d <= reg_c;
        2'b10:   reg_d <= {1'b0, reg_d[N-1:1]};
        2'b11:   reg_d <= '0;
        default: reg_d <= reg_d;
      endcase
    end
  end

  // A fresh operand load into A starts a new operation and clears the flag;
  // otherwise any ULA carry/borrow written back to A or C makes it stick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry <= 1'b0;
    end else if (EnA && !Sel_in) begin
      carry <= 1'b0;
    end else if (Sel_in && (EnA || EnC) && ula_cout) begin
      carry <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pronto <= 1'b0;
    end else begin
      pronto <= fim;
    end
  end

  assign saida = reg_d;

endmodule

// File: tb/tb_caminho_de_dados.sv
// tb/tb_caminho_de_dados.sv - self-checking bench for caminho_de_dados
module tb_caminho_de_dados;

  logic       clk;
  logic       rst;
  logic [7:0] dados;
  logic       EnA, EnB, EnC, Sel_in, Sel_R, fim;
  logic [1:0] Op, Op_Reg;
  logic [7:0] saida;
  logic       carry, pronto;

  int checks = 0;
  int errors = 0;

  caminho_de_dados #(.N(8)) dut (
    .clk(clk), .rst(rst), .dados(dados),
    .EnA(EnA), .EnB(EnB), .EnC(EnC),
    .Sel_in(Sel_in), .Sel_R(Sel_R), .Op(Op), .Op_Reg(Op_Reg),
    .fim(fim), .saida(saida), .carry(carry), .pronto(pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one control state, then let it take effect at the next edge.
  task automatic step(input logic ea, input logic eb, input logic ec,
                      input logic si, input logic sr, input logic [1:0] op,
                      input logic [1:0] opr, input logic f, input logic [7:0] d);
    EnA = ea; EnB = eb; EnC = ec; Sel_in = si; Sel_R = sr;
    Op = op; Op_Reg = opr; fim = f; dados = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'h00);
  endtask

  task automatic load_abc(input int a, input int b, input int c);
    step(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'(a));
    step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 8'(b));
    step(0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 8'(c));
  endtask

  // Reference model: the instruction result from plain integer arithmetic.
  function automatic void model(input int instr, input int a, input int b, input int c,
                                output int s, output int cy, output int pre_shift);
    int t1, t2;
    t1 = a + b;
    cy = (t1 > 255) ? 1 : 0;
    t1 = t1 % 256;
    if (instr == 0) begin
      t2 = t1 + b;
      if (t2 > 255) cy = 1;
      t2 = t2 % 256;
      if (t2 < c) cy = 1;
      s = (t2 - c + 256) % 256;
      pre_shift = s;
    end else begin
      t2 = t1 + c;
      if (t2 > 255) cy = 1;
      pre_shift = t2 % 256;
      s = pre_shift / 2;
    end
  endfunction

  // Full control sequence: loads, instruction body, fim, one trailing idle.
  task automatic run_instr(input int instr, input int a, input int b, input int c,
                           output int s, output int cy, output int pre_shift,
                           output int p_fim, output int p_after);
    load_abc(a, b, c);
    if (instr == 0) begin
      step(1, 0, 0, 1, 0, 2'b01, 2'b00, 0, 8'h00);
      step(1, 0, 0, 1, 0, 2'b01, 2'b00, 0, 8'h00);
      step(0, 0, 1, 1, 1, 2'b10, 2'b00, 0, 8'h00);
      step(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 8'h00);
      pre_shift = int'(saida);
    end else begin
      step(1, 0, 0, 1, 0, 2'b01, 2'b00, 0, 8'h00);
      step(0, 0, 1, 1, 1, 2'b01, 2'b00, 0, 8'h00);
      step(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 8'h00);
      pre_shift = int'(saida);
      step(0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 8'h00);
    end
    step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 8'h00);
    s = int'(saida);
    cy = int'(carry);
    p_fim = int'(pronto);
    idle();
    p_after = int'(pronto);
  endtask

  task automatic test_reset();
    int s, cy, ps, p1, p2;
    rst = 1'b0;
    idle();
    checks++;
    if (saida !== 8'd0 || carry !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: saida=%0d carry=%0b pronto=%0b, want 0/0/0", saida, carry, pronto);
    end
    rst = 1'b1;
    idle();
    // Leave nonzero state behind, then reset after A and B loads.
    run_instr(1, 200, 100, 50, s, cy, ps, p1, p2);
    step(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'd10);
    step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 8'd20);
    step(1, 0, 0, 1, 0, 2'b01, 2'b00, 0, 8'd0);
    step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 8'd0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (saida !== 8'd0 || carry !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: saida=%0d carry=%0b pronto=%0b, want 0/0/0", saida, carry, pronto);
    end
    #2 rst = 1'b1;
    idle();
    // No partial operand survives: D <= C with C reset, and A passes through ULA as 0.
    step(0, 0, 1, 1, 0, 2'b01, 2'b00, 0, 8'd0);
    step(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 8'd0);
    checks++;
    if (saida !== 8'd0) begin
      errors++;
      $display("FAIL reset_no_partial: saida=%0d, want 0", saida);
    end
  endtask

  task automatic test_directed(input string name, input int instr,
                               input int a, input int b, input int c,
                               input int want_s, input int want_cy, input int want_pre);
    int s, cy, ps, p1, p2;
    run_instr(instr, a, b, c, s, cy, ps, p1, p2);
    checks++;
    if (s !== want_s) begin
      errors++;
      $display("FAIL %s saida: got %0d, want %0d", name, s, want_s);
    end
    checks++;
    if (cy !== want_cy) begin
      errors++;
      $display("FAIL %s carry: got %0d, want %0d", name, cy, want_cy);
    end
    checks++;
    if (ps !== want_pre) begin
      errors++;
      $display("FAIL %s pre_shift: got %0d, want %0d", name, ps, want_pre);
    end
    checks++;
    if (p1 !== 1 || p2 !== 0) begin
      errors++;
      $display("FAIL %s pronto: got %0d then %0d, want 1 then 0", name, p1, p2);
    end
  endtask

  task automatic test_carry_clear();
    int s, cy, ps, p1, p2;
    run_instr(0, 1, 1, 9, s, cy, ps, p1, p2);
    checks++;
    if (carry !== 1'b1) begin
      errors++;
      $display("FAIL carry_sticky: got %0b, want 1", carry);
    end
    // Idle cycles and a B load must not touch the flag.
    step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 8'd7);
    checks++;
    if (carry !== 1'b1 || saida !== 8'd250) begin
      errors++;
      $display("FAIL carry_hold: carry=%0b saida=%0d, want 1/250", carry, saida);
    end
    step(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'd4);
    checks++;
    if (carry !== 1'b0) begin
      errors++;
      $display("FAIL carry_clear_on_load: got %0b, want 0", carry);
    end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 8'h3C);
    step(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 8'h00);
    checks++;
    if (saida !== 8'h3C) begin
      errors++;
      $display("FAIL simul_load_c: got %0h, want 3c", saida);
    end
    step(0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 8'h00);
    checks++;
    if (saida !== 8'h00) begin
      errors++;
      $display("FAIL simul_clear: got %0h, want 0", saida);
    end
    // A also got 0x3C: copy it to C through the ULA pass-through, then to D.
    step(0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 8'h00);
    step(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 8'h00);
    checks++;
    if (saida !== 8'h3C) begin
      errors++;
      $display("FAIL simul_load_a: got %0h, want 3c", saida);
    end
    // X&Y with Y=C: 0x3C & 0x3C written to A then read back via C.
    step(1, 0, 0, 1, 1, 2'b11, 2'b00, 0, 8'h00);
    step(0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 8'h00);
    step(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 8'h00);
    checks++;
    if (saida !== 8'h3C) begin
      errors++;
      $display("FAIL ula_and: got %0h, want 3c", saida);
    end
  endtask

  task automatic test_random(input int n);
    int a, b, c, instr, s, cy, ps, p1, p2, es, ecy, eps;
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 255));
      instr = int'($urandom_range(0, 1));
      model(instr, a, b, c, es, ecy, eps);
      run_instr(instr, a, b, c, s, cy, ps, p1, p2);
      checks++;
      if (s !== es || cy !== ecy || ps !== eps || p1 !== 1 || p2 !== 0) begin
        errors++;
        $display("FAIL random[%0d] i=%0d a=%0d b=%0d c=%0d: saida=%0d carry=%0d pre=%0d pronto=%0d/%0d, want %0d/%0d/%0d/1/0",
                 i, instr, a, b, c, s, cy, ps, p1, p2, es, ecy, eps);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    EnA = 0; EnB = 0; EnC = 0; Sel_in = 0; Sel_R = 0;
    Op = 2'b00; Op_Reg = 2'b00; fim = 0; dados = 8'h00;
    test_reset();
    test_directed("instr0_5_3_4", 0, 5, 3, 4, 7, 0, 7);
    test_directed("instr1_5_3_4", 1, 5, 3, 4, 6, 0, 12);
    test_directed("instr1_overflow", 1, 200, 100, 50, 47, 1, 94);
    test_directed("instr0_borrow", 0, 1, 1, 9, 250, 1, 250);
    test_carry_clear();
    test_simultaneous();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
